// File: rtl/sprite_blit_engine_if.sv
// Sprite blitter bus: start/position request, status, ROM read port
// and framebuffer write port with valid/ready style acceptance.
interface sprite_blit_engine_if;
  logic        start;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic        dir;
  logic        busy;
  logic        done;
  logic [5:0]  rom_dx;
  logic [5:0]  rom_dy;
  logic [7:0]  rom_data;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;

  modport master (
    output start, pos_x, pos_y, dir,
    output rom_data, fb_ready,
    input  busy, done, rom_dx, rom_dy,
    input  fb_we, fb_addr, fb_data
  );

  modport slave (
    input  start, pos_x, pos_y, dir,
    input  rom_data, fb_ready,
    output busy, done, rom_dx, rom_dy,
    output fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/sprite_blit_engine.sv
// Sprite blitter: walks a SPR_W x SPR_H ROM row-major, optional mirror,
// writes opaque on-screen texels. Ports: Clk, Reset_n, bus (slave).
module sprite_blit_engine #(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 24,
  parameter int SCR_W  = 640,
  parameter int SCR_H  = 480,
  parameter int TRANSP = 0
) (
  input logic             Clk,
  input logic             Reset_n,
  sprite_blit_engine_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic        dir_q, dir_d;
  logic [5:0]  c_q, c_d;
  logic [5:0]  r_q, r_d;
  logic [5:0]  dx_q, dx_d;
  logic [5:0]  dy_q, dy_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        stall;
  logic        last;
  logic        wr;
  logic [11:0] x_s;
  logic [10:0] y_s;
  logic [18:0] addr_c;
  logic [5:0]  c_nx;
  logic [5:0]  r_nx;

  // The ROM output belongs to the address currently driven, so the
  // column/row counters double as the evaluation-stage coordinates.
  assign stall = we_q && !bus.fb_ready;
  assign last  = (c_q == 6'(SPR_W - 1))
              && (r_q == 6'(SPR_H - 1));
  assign x_s   = {px_q[10], px_q} + {6'd0, c_q};
  assign y_s   = {1'b0, py_q} + {5'd0, r_q};
  assign wr    = (bus.rom_data != 8'(TRANSP))
              && !x_s[11]
              && (x_s[10:0] < 11'(SCR_W))
              && (y_s < 11'(SCR_H));
  assign addr_c = 19'(y_s) * 19'(SCR_W)
               + 19'(x_s[10:0]);

  always_comb begin
    c_nx = c_q + 6'd1;
    r_nx = r_q;
    if (c_q == 6'(SPR_W - 1)) begin
      c_nx = 6'd0;
      r_nx = r_q + 6'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    dir_d   = dir_q;
    c_d     = c_q;
    r_d     = r_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    busy_d  = busy_q;
    done_d  = done_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          px_d    = bus.pos_x;
          py_d    = bus.pos_y;
          dir_d   = bus.dir;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy_d  = 1'b1;
        c_d     = 6'd0;
        r_d     = 6'd0;
        dx_d    = dir_q ? 6'd0 : 6'(SPR_W - 1);
        dy_d    = 6'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!stall) begin
          we_d = wr;
          if (wr) begin
            addr_d = addr_c;
            data_d = bus.rom_data;
          end
          if (last) begin
            state_d = S_DRAIN;
          end else begin
            c_d  = c_nx;
            r_d  = r_nx;
            dx_d = dir_q ? c_nx
                         : 6'(SPR_W - 1) - c_nx;
            dy_d = r_nx;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      px_q    <= '0;
      py_q    <= '0;
      dir_q   <= 1'b0;
      c_q     <= '0;
      r_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      dir_q   <= dir_d;
      c_q     <= c_d;
      r_q     <= r_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rom_dx  = dx_q;
  assign bus.rom_dy  = dy_q;
  assign bus.fb_we   = we_q;
  assign bus.fb_addr = addr_q;
  assign bus.fb_data = data_q;

endmodule
